ldl_sfifo_v2: RTL and testbench

LDL_SFIFO_V2 -- requirements
Module: ldl_sfifo_v2

---
 rtl/ldl_sfifo_v2.sv | 153 +++++++++++++++
 tb/tb_ldl_sfifo_v2.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ldl_sfifo_v2.sv
// ldl_sfifo_v2: single-clock FIFO, depth 2**AW, with registered level and flags.
// AHEAD=1 gives first-word-fall-through output; AHEAD=0 gives a 1-cycle registered read.
// Ports in : clk, rst (async, active-high), we, re, din[DW], err_clr
// Ports out: dout[DW], empty, full, aempty, afull, level[AW+1], wcnt[AW], rcnt[AW], ovf, udf
// Macro LDL_SFIFO_V2_ERR_EN enables the sticky ovf/udf flags; otherwise they are tied low.
module ldl_sfifo_v2 #(
    parameter int DW     = 8,
    parameter int AW     = 4,
    parameter int AHEAD  = 1,
    parameter int AFULL  = 2**AW - 2,
    parameter int AEMPTY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [DW-1:0] din,
    input  logic          err_clr,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic          aempty,
    output logic          afull,
    output logic [AW:0]   level,
    output logic [AW-1:0] wcnt,
    output logic [AW-1:0] rcnt,
    output logic          ovf,
    output logic          udf
);

    localparam int          DEPTH   = 2**AW;
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_AF    = (AW+1)'(AFULL);
    localparam logic [AW:0] C_AE    = (AW+1)'(AEMPTY);
    localparam logic [AW:0] C_ONE   = (AW+1)'(1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wcnt;
    logic [AW-1:0] r_rcnt;
    logic [AW:0]   r_level;
    logic          r_empty;
    logic          r_full;
    logic          r_aempty;
    logic          r_afull;

    logic          w_wr;
    logic          w_rd;
    logic [AW:0]   w_lvl_nxt;

    // Acceptance uses the registered flags, so a full FIFO with we=re=1
    // accepts only the read and an empty one only the write.
    assign w_wr = we & ~r_full;
    assign w_rd = re & ~r_empty;

    always_comb begin
        w_lvl_nxt = r_level;
        if (w_wr && !w_rd) begin
            w_lvl_nxt = r_level + C_ONE;
        end else if (w_rd && !w_wr) begin
            w_lvl_nxt = r_level - C_ONE;
        end
    end

    // Storage is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wcnt] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt   <= '0;
            r_rcnt   <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_aempty <= 1'b1;
            r_afull  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wcnt <= r_wcnt + AW'(1);
            end
            if (w_rd) begin
                r_rcnt <= r_rcnt + AW'(1);
            end
            r_level  <= w_lvl_nxt;
            r_empty  <= (w_lvl_nxt == '0);
            r_full   <= (w_lvl_nxt == C_DEPTH);
            r_aempty <= (w_lvl_nxt <= C_AE);
            r_afull  <= (w_lvl_nxt >= C_AF);
        end
    end

    generate
        if (AHEAD != 0) begin : g_fwft
            // Head word shown directly; forced to zero while nothing is stored
            // so the output matches its reset value when empty.
            assign dout = r_empty ? '0 : r_mem[r_rcnt];
        end else begin : g_reg
            logic [DW-1:0] r_dout;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dout <= '0;
                end else if (w_rd) begin
                    r_dout <= r_mem[r_rcnt];
                end
            end
            assign dout = r_dout;
        end
    endgenerate

`ifdef LDL_SFIFO_V2_ERR_EN
    logic r_ovf;
    logic r_udf;

    // A fresh error outranks err_clr so it is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (we && r_full) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
            if (re && r_empty) begin
                r_udf <= 1'b1;
            end else if (err_clr) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

    assign wcnt   = r_wcnt;
    assign rcnt   = r_rcnt;
    assign level  = r_level;
    assign empty  = r_empty;
    assign full   = r_full;
    assign aempty = r_aempty;
    assign afull  = r_afull;

endmodule

// File: tb/tb_ldl_sfifo_v2.sv
// tb_ldl_sfifo_v2: directed table-driven bench for ldl_sfifo_v2.
// Covers FWFT (u_fwft) and registered-read (u_reg) builds.
module tb_ldl_sfifo_v2;

`ifdef LDL_SFIFO_V2_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       err_clr;
    logic       we, re;
    logic [7:0] din;
    logic [7:0] dout;
    logic       empty, full, aempty, afull, ovf, udf;
    logic [4:0] level;
    logic [3:0] wcnt, rcnt;

    logic       we2, re2;
    logic [7:0] din2;
    logic [7:0] dout2;
    logic       empty2, full2, aempty2, afull2, ovf2, udf2;
    logic [4:0] level2;
    logic [3:0] wcnt2, rcnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ldl_sfifo_v2 #(.DW(8), .AW(4), .AHEAD(1)) u_fwft (
        .clk(clk), .rst(rst), .we(we), .re(re), .din(din), .err_clr(err_clr),
        .dout(dout), .empty(empty), .full(full), .aempty(aempty), .afull(afull),
        .level(level), .wcnt(wcnt), .rcnt(rcnt), .ovf(ovf), .udf(udf)
    );

    ldl_sfifo_v2 #(.DW(8), .AW(4), .AHEAD(0)) u_reg (
        .clk(clk), .rst(rst), .we(we2), .re(re2), .din(din2), .err_clr(err_clr),
        .dout(dout2), .empty(empty2), .full(full2), .aempty(aempty2), .afull(afull2),
        .level(level2), .wcnt(wcnt2), .rcnt(rcnt2), .ovf(ovf2), .udf(udf2)
    );

    typedef struct {
        logic       we;
        logic       re;
        logic       clr;
        logic [7:0] din;
        logic [4:0] lvl;
        logic       emp;
        logic       ful;
        logic       ae;
        logic       af;
        logic       cd;
        logic [7:0] dout;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t tv[41];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " level"}, 32'(level), 0);
        chk({tag, " empty"}, 32'(empty), 1);
        chk({tag, " full"}, 32'(full), 0);
        chk({tag, " aempty"}, 32'(aempty), 1);
        chk({tag, " afull"}, 32'(afull), 0);
        chk({tag, " dout"}, 32'(dout), 0);
        chk({tag, " wcnt"}, 32'(wcnt), 0);
        chk({tag, " rcnt"}, 32'(rcnt), 0);
        chk({tag, " ovf"}, 32'(ovf), 0);
        chk({tag, " udf"}, 32'(udf), 0);
    endtask

    initial begin
        logic [7:0] nr, nw;
        int l;

        // 20 writes 0xA1.., 20 reads, then one error-clear cycle.
        for (int i = 0; i < 20; i++) begin
            l = (i + 1 > 16) ? 16 : i + 1;
            tv[i] = '{we: 1'b1, re: 1'b0, clr: 1'b0, din: 8'(8'hA1 + i),
                      lvl: 5'(l), emp: 1'b0, ful: (l == 16), ae: (l <= 1),
                      af: (l >= 14), cd: 1'b1, dout: 8'hA1,
                      ovf: ERR && (i >= 16), udf: 1'b0};
        end
        for (int j = 0; j < 20; j++) begin
            l = (j < 16) ? 15 - j : 0;
            tv[20 + j] = '{we: 1'b0, re: 1'b1, clr: 1'b0, din: 8'h00,
                           lvl: 5'(l), emp: (l == 0), ful: 1'b0, ae: (l <= 1),
                           af: (l >= 14), cd: (l != 0), dout: 8'(8'hA2 + j),
                           ovf: ERR, udf: ERR && (j >= 16)};
        end
        tv[40] = '{we: 1'b0, re: 1'b0, clr: 1'b1, din: 8'h00, lvl: 5'd0,
                   emp: 1'b1, ful: 1'b0, ae: 1'b1, af: 1'b0, cd: 1'b0,
                   dout: 8'h00, ovf: 1'b0, udf: 1'b0};

        rst = 1'b1; err_clr = 1'b0;
        we = 1'b0; re = 1'b0; din = '0;
        we2 = 1'b0; re2 = 1'b0; din2 = '0;
        tick();
        tick();
        chk_reset("rst0");
        chk("rst0 dout2", 32'(dout2), 0);
        rst = 1'b0;

        for (int k = 0; k < 41; k++) begin
            we = tv[k].we; re = tv[k].re; err_clr = tv[k].clr; din = tv[k].din;
            tick();
            chk($sformatf("v%0d level", k), 32'(level), 32'(tv[k].lvl));
            chk($sformatf("v%0d empty", k), 32'(empty), 32'(tv[k].emp));
            chk($sformatf("v%0d full", k), 32'(full), 32'(tv[k].ful));
            chk($sformatf("v%0d aempty", k), 32'(aempty), 32'(tv[k].ae));
            chk($sformatf("v%0d afull", k), 32'(afull), 32'(tv[k].af));
            chk($sformatf("v%0d ovf", k), 32'(ovf), 32'(tv[k].ovf));
            chk($sformatf("v%0d udf", k), 32'(udf), 32'(tv[k].udf));
            if (tv[k].cd) begin
                chk($sformatf("v%0d dout", k), 32'(dout), 32'(tv[k].dout));
            end
        end
        we = 1'b0; re = 1'b0; err_clr = 1'b0;

        // Full FIFO, simultaneous read+write: only the read goes through.
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; din = 8'(i);
            tick();
        end
        chk("fill level", 32'(level), 16);
        chk("fill full", 32'(full), 1);
        we = 1'b1; re = 1'b1; din = 8'hEE;
        tick();
        we = 1'b0; re = 1'b0;
        chk("fullrw level", 32'(level), 15);
        chk("fullrw full", 32'(full), 0);
        chk("fullrw ovf", 32'(ovf), 32'(ERR));
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain%0d dout", i), 32'(dout), 32'(i));
            re = 1'b1;
            tick();
        end
        re = 1'b0;
        chk("drain level", 32'(level), 0);
        chk("drain empty", 32'(empty), 1);

        // Empty FIFO, simultaneous read+write: only the write goes through.
        we = 1'b1; re = 1'b1; din = 8'h77;
        tick();
        we = 1'b0; re = 1'b0;
        chk("emprw level", 32'(level), 1);
        chk("emprw empty", 32'(empty), 0);
        chk("emprw dout", 32'(dout), 32'h77);
        chk("emprw udf", 32'(udf), 32'(ERR));
        re = 1'b1;
        tick();
        chk("emprw2 empty", 32'(empty), 1);

        // New underflow with err_clr in the same cycle keeps the flag.
        err_clr = 1'b1; re = 1'b1;
        tick();
        chk("clrprio udf", 32'(udf), 32'(ERR));
        chk("clrprio ovf", 32'(ovf), 0);
        re = 1'b0;
        tick();
        err_clr = 1'b0;
        chk("clr udf", 32'(udf), 0);

        // Steady-state streaming at level 3 across two pointer wraps.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nr = 8'h40; nw = 8'h40;
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; din = nw; nw++;
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            if (dout !== nr || level !== 5'd3) begin
                chk($sformatf("stream%0d dout", i), 32'(dout), 32'(nr));
                chk($sformatf("stream%0d level", i), 32'(level), 3);
            end else begin
                checks++;
            end
            we = 1'b1; re = 1'b1; din = nw; nw++;
            tick();
            nr++;
        end
        we = 1'b0; re = 1'b0;
        chk("stream level", 32'(level), 3);
        chk("stream wcnt", 32'(wcnt), 11);
        chk("stream rcnt", 32'(rcnt), 8);
        chk("stream dout", 32'(dout), 32'(nr));

        // Asynchronous reset at level 9.
        for (int i = 0; i < 6; i++) begin
            we = 1'b1; din = 8'(8'h60 + i);
            tick();
        end
        we = 1'b0;
        chk("pre-rst level", 32'(level), 9);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async");
        tick();
        rst = 1'b0; we = 1'b1; din = 8'h5A;
        tick();
        we = 1'b0;
        chk("post-rst level", 32'(level), 1);
        chk("post-rst dout", 32'(dout), 32'h5A);

        // Registered-read instance: 1-cycle latency and hold.
        chk("reg rst dout", 32'(dout2), 0);
        we2 = 1'b1; din2 = 8'h11;
        tick();
        we2 = 1'b0;
        chk("reg wr level", 32'(level2), 1);
        chk("reg wr dout", 32'(dout2), 0);
        re2 = 1'b1;
        tick();
        re2 = 1'b0;
        chk("reg rd dout", 32'(dout2), 32'h11);
        chk("reg rd level", 32'(level2), 0);
        tick();
        chk("reg hold dout", 32'(dout2), 32'h11);
        we2 = 1'b1; din2 = 8'h22;
        tick();
        din2 = 8'h33;
        tick();
        we2 = 1'b0; re2 = 1'b1;
        tick();
        re2 = 1'b0;
        chk("reg rd2 dout", 32'(dout2), 32'h22);
        tick();
        chk("reg hold2 dout", 32'(dout2), 32'h22);
        re2 = 1'b1;
        tick();
        re2 = 1'b0;
        chk("reg rd3 dout", 32'(dout2), 32'h33);
        chk("reg rd3 empty", 32'(empty2), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
